branch_resolve: RTL

Resolves branches and jumps in ID, one stage downstream of the ID branch source mux. Takes the forwarded `source_a`/`source_b` operands, decodes the branch type, and evaluates the condition. Computes the target and registers a redirect to IF, holding it under an `if_ready` handshake. Also tracks the branch delay slot, registers link data for linking branches, and keeps taken/not-taken counters.

---
 rtl/branch_resolve_pkg.sv | 39 +++
 rtl/brc_cmp.sv | 31 +++
 rtl/branch_resolve.sv | 106 ++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for ID-stage branch resolution: branch codes, data width and FSM states.
package branch_resolve_pkg;

    localparam int W_DATA = 32;

    typedef enum logic [3:0] {
        BRC_NONE   = 4'd0,
        BRC_BEQ    = 4'd1,
        BRC_BNE    = 4'd2,
        BRC_BLEZ   = 4'd3,
        BRC_BGTZ   = 4'd4,
        BRC_BLTZ   = 4'd5,
        BRC_BGEZ   = 4'd6,
        BRC_BLTZAL = 4'd7,
        BRC_BGEZAL = 4'd8,
        BRC_J      = 4'd9,
        BRC_JAL    = 4'd10,
        BRC_JR     = 4'd11,
        BRC_JALR   = 4'd12
    } brc_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    function automatic logic brc_is_link(input logic [3:0] t);
        return (t == BRC_BLTZAL) || (t == BRC_BGEZAL) || (t == BRC_JAL) || (t == BRC_JALR);
    endfunction

    function automatic logic brc_is_reg_jump(input logic [3:0] t);
        return (t == BRC_JR) || (t == BRC_JALR);
    endfunction

    function automatic logic brc_is_abs_jump(input logic [3:0] t);
        return (t == BRC_J) || (t == BRC_JAL);
    endfunction

endpackage

// File: rtl/brc_cmp.sv
// Combinational branch condition evaluator; operands are treated as signed 32-bit values.
module brc_cmp
    import branch_resolve_pkg::*;
(
    input  logic [3:0]        brc_type,
    input  logic [W_DATA-1:0] a,
    input  logic [W_DATA-1:0] b,
    output logic              taken
);

    localparam logic signed [W_DATA-1:0] ZERO = '0;

    logic signed [W_DATA-1:0] sa;
    assign sa = a;

    always_comb begin
        taken = 1'b0;
        case (brc_type)
            BRC_BEQ:                  taken = (a == b);
            BRC_BNE:                  taken = (a != b);
            BRC_BLEZ:                 taken = (sa <= ZERO);
            BRC_BGTZ:                 taken = (sa > ZERO);
            BRC_BLTZ, BRC_BLTZAL:     taken = (sa < ZERO);
            BRC_BGEZ, BRC_BGEZAL:     taken = (sa >= ZERO);
            BRC_J, BRC_JAL,
            BRC_JR, BRC_JALR:         taken = 1'b1;
            default:                  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: condition, target, held redirect toward IF, link write,
// delay-slot tracking and taken/not-taken counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic [3:0]        brc_type,
    input  logic [W_DATA-1:0] id_pc,
    input  logic [15:0]       imm,
    input  logic [25:0]       jidx,
    input  logic [W_DATA-1:0] source_a,
    input  logic [W_DATA-1:0] source_b,
    input  logic              if_ready,
    output logic              redirect_valid,
    output logic [W_DATA-1:0] redirect_pc,
    output logic              link_valid,
    output logic [W_DATA-1:0] link_data,
    output logic              ds_flag,
    output logic              adel,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  ntaken_cnt
);

    state_t state, state_next;

    logic              consume;
    logic              brc_consume;
    logic              cond_taken;
    logic              misalign;
    logic              taken_eff;
    logic [W_DATA-1:0] pc_plus4;
    logic [W_DATA-1:0] target;

    brc_cmp u_brc_cmp (
        .brc_type (brc_type),
        .a        (source_a),
        .b        (source_b),
        .taken    (cond_taken)
    );

    assign busy           = (state == ST_PEND);
    assign redirect_valid = (state == ST_PEND);

    assign consume     = id_valid && !id_stall && !busy;
    assign brc_consume = consume && (brc_type != BRC_NONE);

    // A misaligned register jump raises adel instead of redirecting.
    assign misalign  = brc_is_reg_jump(brc_type) && (source_a[1:0] != 2'b00);
    assign taken_eff = cond_taken && !misalign;

    assign pc_plus4 = id_pc + 32'd4;

    always_comb begin
        target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        if (brc_is_abs_jump(brc_type)) begin
            target = {pc_plus4[31:28], jidx, 2'b00};
        end else if (brc_is_reg_jump(brc_type)) begin
            target = source_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (brc_consume && taken_eff) state_next = ST_PEND;
            ST_PEND: if (if_ready)                 state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc <= '0;
            link_valid  <= 1'b0;
            link_data   <= '0;
            ds_flag     <= 1'b0;
            adel        <= 1'b0;
            taken_cnt   <= '0;
            ntaken_cnt  <= '0;
        end else begin
            link_valid <= brc_consume && brc_is_link(brc_type);
            adel       <= brc_consume && misalign;
            if (brc_consume && taken_eff) redirect_pc <= target;
            if (brc_consume && brc_is_link(brc_type)) link_data <= id_pc + 32'd8;
            // A branch sitting in a delay slot keeps the flag set.
            if (brc_consume)  ds_flag <= 1'b1;
            else if (consume) ds_flag <= 1'b0;
            if (brc_consume) begin
                if (taken_eff) taken_cnt  <= taken_cnt + CNT_W'(1);
                else           ntaken_cnt <= ntaken_cnt + CNT_W'(1);
            end
        end
    end

endmodule
